// File: rtl/sc_leaf_ctrl.sv
// Leaf-pair decision controller for a successive-cancellation decoder: accepts LLR pairs,
// decides u(2k)/u(2k+1), and accumulates the decoded frame. Optional macro: FROZEN_SKIP_EN.
module sc_leaf_ctrl (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [1:0]   len_sel,
    input  logic [511:0] frozen_mask,
    input  logic         llr_valid,
    output logic         llr_ready,
    input  logic [16:0]  llr_1,
    input  logic [16:0]  llr_2,
    output logic [7:0]   pair_idx,
    output logic         ps_valid,
    output logic         ps_u1,
    output logic         ps_u2,
    output logic [511:0] dec_bits,
    output logic         busy,
    output logic         done,
    output logic         skip
);

    // state    | meaning
    // IDLE     | waiting for start
    // WAIT_LLR | llr_ready high, waiting for the pair handshake (or a frozen-pair skip)
    // DECIDE   | ps_valid strobe for the decided pair, advance or finish
    // DONE     | done pulse, busy released
    typedef enum logic [1:0] {IDLE, WAIT_LLR, DECIDE, DONE} state_t;

`ifdef FROZEN_SKIP_EN
    localparam logic SKIP_EN = 1'b1;
`else
    localparam logic SKIP_EN = 1'b0;
`endif

    state_t      state;
    logic [1:0]  len_q;
    logic [7:0]  last_idx;
    logic [7:0]  nxt_idx;
    logic [8:0]  bit_lo;
    logic [8:0]  bit_hi;
    logic        f1;
    logic        f2;
    logic        nxt_both_frozen;
    logic        s1;
    logic        s2;
    logic [17:0] ext1;
    logic [17:0] ext2;
    logic [17:0] mag1;
    logic [17:0] mag2;
    logic        comp;
    logic        u1_d;
    logic        u2_d;

    always_comb begin
        case (len_q)
            2'd0:    last_idx = 8'd63;
            2'd1:    last_idx = 8'd127;
            default: last_idx = 8'd255;
        endcase
    end

    assign nxt_idx         = pair_idx + 8'd1;
    assign bit_lo          = {pair_idx, 1'b0};
    assign bit_hi          = {pair_idx, 1'b1};
    assign f1              = frozen_mask[bit_lo];
    assign f2              = frozen_mask[bit_hi];
    assign nxt_both_frozen = frozen_mask[{nxt_idx, 1'b0}] & frozen_mask[{nxt_idx, 1'b1}];

    // 18-bit magnitudes so that |-65536| is representable
    assign s1   = llr_1[16];
    assign s2   = llr_2[16];
    assign ext1 = {llr_1[16], llr_1};
    assign ext2 = {llr_2[16], llr_2};
    assign mag1 = s1 ? (~ext1 + 18'd1) : ext1;
    assign mag2 = s2 ? (~ext2 + 18'd1) : ext2;
    assign comp = (mag1 >= mag2);
    assign u1_d = ~f1 & (s1 ^ s2);
    assign u2_d = ~f2 & (f1 ? (comp ? s1 : s2) : s2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            len_q     <= 2'd0;
            pair_idx  <= 8'd0;
            dec_bits  <= '0;
            llr_ready <= 1'b0;
            ps_valid  <= 1'b0;
            ps_u1     <= 1'b0;
            ps_u2     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            skip      <= 1'b0;
        end else begin
            ps_valid <= 1'b0;
            skip     <= 1'b0;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= WAIT_LLR;
                        len_q     <= len_sel;
                        pair_idx  <= 8'd0;
                        dec_bits  <= '0;
                        busy      <= 1'b1;
                        llr_ready <= ~(SKIP_EN & frozen_mask[0] & frozen_mask[1]);
                    end
                end
                WAIT_LLR: begin
                    if (SKIP_EN && f1 && f2) begin
                        state            <= DECIDE;
                        llr_ready        <= 1'b0;
                        ps_valid         <= 1'b1;
                        ps_u1            <= 1'b0;
                        ps_u2            <= 1'b0;
                        skip             <= 1'b1;
                        dec_bits[bit_lo] <= 1'b0;
                        dec_bits[bit_hi] <= 1'b0;
                    end else if (llr_valid && llr_ready) begin
                        // decision is registered at the handshake so it appears in DECIDE
                        state            <= DECIDE;
                        llr_ready        <= 1'b0;
                        ps_valid         <= 1'b1;
                        ps_u1            <= u1_d;
                        ps_u2            <= u2_d;
                        dec_bits[bit_lo] <= u1_d;
                        dec_bits[bit_hi] <= u2_d;
                    end
                end
                DECIDE: begin
                    if (pair_idx == last_idx) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state     <= WAIT_LLR;
                        pair_idx  <= nxt_idx;
                        llr_ready <= ~(SKIP_EN & nxt_both_frozen);
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sc_leaf_ctrl.sv
// Directed bench for sc_leaf_ctrl: frames, decision corner cases, stalls, reset, ignored starts.
module tb_sc_leaf_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [1:0]   len_sel;
    logic [511:0] frozen_mask;
    logic         llr_valid;
    logic         llr_ready;
    logic [16:0]  llr_1;
    logic [16:0]  llr_2;
    logic [7:0]   pair_idx;
    logic         ps_valid;
    logic         ps_u1;
    logic         ps_u2;
    logic [511:0] dec_bits;
    logic         busy;
    logic         done;
    logic         skip;

    int vec = 0;
    int miscmp = 0;

    sc_leaf_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len_sel(len_sel),
        .frozen_mask(frozen_mask), .llr_valid(llr_valid), .llr_ready(llr_ready),
        .llr_1(llr_1), .llr_2(llr_2), .pair_idx(pair_idx), .ps_valid(ps_valid),
        .ps_u1(ps_u1), .ps_u2(ps_u2), .dec_bits(dec_bits), .busy(busy),
        .done(done), .skip(skip)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // returns {u2, u1}
    function automatic logic [1:0] model(input logic f1, input logic f2, input int a, input int b);
        logic sa, sb, u1, u2;
        int ma, mb;
        sa = (a < 0);
        sb = (b < 0);
        ma = (a < 0) ? -a : a;
        mb = (b < 0) ? -b : b;
        u1 = !f1 && (sa != sb);
        if (f2)      u2 = 1'b0;
        else if (f1) u2 = (ma >= mb) ? sa : sb;
        else         u2 = sb;
        return {u2, u1};
    endfunction

    task automatic pulse_start(input logic [1:0] ls);
        len_sel = ls;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    // handshake one pair; returns what was seen in the DECIDE cycle, ends one cycle later
    task automatic send_pair(input int a, input int b, output logic v, output logic u1,
                             output logic u2, output logic [7:0] idx);
        int n = 0;
        while (llr_ready !== 1'b1 && n < 20) begin
            tick;
            n++;
        end
        if (llr_ready !== 1'b1) begin
            vec++; miscmp++;
            $display("FAIL ready_timeout: llr_ready=%b after %0d cycles, want 1", llr_ready, n);
        end
        llr_1 = a[16:0];
        llr_2 = b[16:0];
        llr_valid = 1'b1;
        tick;
        llr_valid = 1'b0;
        v = ps_valid; u1 = ps_u1; u2 = ps_u2; idx = pair_idx;
        tick;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; len_sel = 2'd0; frozen_mask = '0;
        llr_valid = 1'b0; llr_1 = '0; llr_2 = '0;
        #12;
        vec++;
        if ({llr_ready, ps_valid, ps_u1, ps_u2, busy, done, skip, pair_idx} !== 15'd0) begin
            miscmp++;
            $display("FAIL reset_ctl: got %b, want all zero",
                     {llr_ready, ps_valid, ps_u1, ps_u2, busy, done, skip, pair_idx});
        end
        vec++;
        if (dec_bits !== '0) begin miscmp++; $display("FAIL reset_dec: dec_bits nonzero, want 0"); end
        rst_n = 1'b1;
        tick; tick;
        vec++;
        if ({busy, llr_ready} !== 2'b00) begin
            miscmp++; $display("FAIL reset_idle: busy/ready=%b, want 00", {busy, llr_ready});
        end
    endtask

    task automatic test_idle_llr;
        llr_valid = 1'b1; llr_1 = 17'd5; llr_2 = 17'd3;
        for (int i = 0; i < 3; i++) begin
            tick;
            vec++;
            if ({ps_valid, llr_ready, busy} !== 3'b000) begin
                miscmp++; $display("FAIL idle_llr: valid/ready/busy=%b, want 000", {ps_valid, llr_ready, busy});
            end
        end
        llr_valid = 1'b0;
    endtask

    task automatic test_full_frame;
        logic v, u1, u2;
        logic [7:0] idx;
        frozen_mask = '0;
        pulse_start(2'd0);
        vec++;
        if ({busy, llr_ready, pair_idx} !== {2'b11, 8'd0}) begin
            miscmp++; $display("FAIL ff_start: busy/ready/idx=%b, want 1100000000", {busy, llr_ready, pair_idx});
        end
        for (int k = 0; k < 64; k++) begin
            send_pair(5, -3, v, u1, u2, idx);
            vec++;
            if ({v, u1, u2, idx} !== {3'b111, k[7:0]}) begin
                miscmp++; $display("FAIL ff_pair: k=%0d got v/u1/u2/idx=%b %b %b %0d, want 1 1 1 %0d", k, v, u1, u2, idx, k);
            end
        end
        vec++;
        if ({done, ps_valid, busy} !== 3'b101) begin
            miscmp++; $display("FAIL ff_done: done/ps_valid/busy=%b, want 101", {done, ps_valid, busy});
        end
        tick;
        vec++;
        if ({done, busy, llr_ready} !== 3'b000) begin
            miscmp++; $display("FAIL ff_after: done/busy/ready=%b, want 000", {done, busy, llr_ready});
        end
        vec++;
        if (dec_bits !== {384'd0, {128{1'b1}}}) begin
            miscmp++; $display("FAIL ff_dec: dec_bits[127:0]=%h upper nonzero=%b", dec_bits[127:0], |dec_bits[511:128]);
        end
    endtask

    task automatic test_decide;
        int a_t[7] = '{-10, 2, -65536, -3, 9, 0, -65536};
        int b_t[7] = '{4, -7, 65535, 5, 9, -1, -65536};
        logic [1:0] e_t[7] = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b00, 2'b11, 2'b10};
        logic v, u1, u2;
        logic [7:0] idx;
        frozen_mask = '0;
        frozen_mask[0] = 1'b1; frozen_mask[2] = 1'b1; frozen_mask[4] = 1'b1;
        frozen_mask[7] = 1'b1; frozen_mask[8] = 1'b1;
        pulse_start(2'd0);
        for (int k = 0; k < 7; k++) begin
            send_pair(a_t[k], b_t[k], v, u1, u2, idx);
            vec++;
            if ({v, u2, u1} !== {1'b1, e_t[k]}) begin
                miscmp++; $display("FAIL decide: k=%0d got v/u2/u1=%b, want 1%b", k, {v, u2, u1}, e_t[k]);
            end
        end
        for (int k = 7; k < 64; k++) send_pair(1, 1, v, u1, u2, idx);
        vec++;
        if (done !== 1'b1) begin miscmp++; $display("FAIL decide_done: done=%b, want 1", done); end
        for (int i = 0; i < 4; i++) tick;
        vec++;
        if (dec_bits !== {498'd0, 14'h2C6A}) begin
            miscmp++; $display("FAIL decide_hold: dec_bits[15:0]=%h, want 2c6a (upper nonzero=%b)", dec_bits[15:0], |dec_bits[511:14]);
        end
    endtask

    task automatic test_stall;
        logic v, u1, u2;
        logic [7:0] idx;
        frozen_mask = '0;
        pulse_start(2'd0);
        send_pair(5, -3, v, u1, u2, idx);
        for (int i = 0; i < 5; i++) begin
            tick;
            vec++;
            if ({llr_ready, ps_valid, pair_idx} !== {2'b10, 8'd1}) begin
                miscmp++; $display("FAIL stall: cycle %0d ready/ps_valid/idx=%b %b %0d, want 1 0 1", i, llr_ready, ps_valid, pair_idx);
            end
        end
    endtask

    // continues the frame left open by test_stall
    task automatic test_reset_mid;
        logic v, u1, u2;
        logic [7:0] idx;
        logic [1:0] m;
        logic [511:0] exp_db;
        int a, b;
        for (int k = 1; k < 37; k++) send_pair(5, -3, v, u1, u2, idx);
        vec++;
        if (pair_idx !== 8'd37) begin miscmp++; $display("FAIL mid_idx: pair_idx=%0d, want 37", pair_idx); end
        #2 rst_n = 1'b0;
        #1;
        vec++;
        if ({llr_ready, ps_valid, ps_u1, ps_u2, busy, done, skip, pair_idx} !== 15'd0 || dec_bits !== '0) begin
            miscmp++; $display("FAIL mid_reset: ctl=%b dec_nonzero=%b, want zeros",
                               {llr_ready, ps_valid, ps_u1, ps_u2, busy, done, skip, pair_idx}, |dec_bits);
        end
        #3 rst_n = 1'b1;
        tick; tick; tick;
        vec++;
        if ({busy, llr_ready, ps_valid} !== 3'b000) begin
            miscmp++; $display("FAIL mid_resume: busy/ready/ps_valid=%b, want 000", {busy, llr_ready, ps_valid});
        end
        frozen_mask = '0;
        for (int k = 0; k < 64; k++) begin
            if (k % 3 == 0) frozen_mask[2*k] = 1'b1;
            if (k % 3 == 1) frozen_mask[2*k+1] = 1'b1;
        end
        exp_db = '0;
        pulse_start(2'd0);
        for (int k = 0; k < 64; k++) begin
            a = (k * 37) % 201 - 100;
            b = (k * 53) % 151 - 75;
            m = model(frozen_mask[2*k], frozen_mask[2*k+1], a, b);
            exp_db[2*k] = m[0];
            exp_db[2*k+1] = m[1];
            send_pair(a, b, v, u1, u2, idx);
            vec++;
            if ({v, u2, u1, idx} !== {1'b1, m, k[7:0]}) begin
                miscmp++; $display("FAIL replay: k=%0d got v/u2/u1=%b idx=%0d, want 1%b idx=%0d", k, {v, u2, u1}, idx, m, k);
            end
        end
        vec++;
        if (done !== 1'b1 || dec_bits !== exp_db) begin
            miscmp++; $display("FAIL replay_end: done=%b dec_bits[127:0]=%h, want 1 %h", done, dec_bits[127:0], exp_db[127:0]);
        end
        tick;
    endtask

    task automatic test_back_to_back;
        logic v, u1, u2;
        logic [7:0] idx;
        frozen_mask = '0;
        pulse_start(2'd1);
        len_sel = 2'd0;
        for (int k = 0; k < 128; k++) begin
            if (k == 10) begin
                start = 1'b1; tick; start = 1'b0;
                vec++;
                if ({busy, pair_idx} !== {1'b1, 8'd10}) begin
                    miscmp++; $display("FAIL busy_start: busy/idx=%b %0d, want 1 10", busy, pair_idx);
                end
            end
            send_pair(1, -1, v, u1, u2, idx);
            if (k == 63) begin
                vec++;
                if (done !== 1'b0) begin miscmp++; $display("FAIL len_hold: done=%b at pair 63, want 0", done); end
            end
        end
        vec++;
        if (done !== 1'b1) begin miscmp++; $display("FAIL b2b_done: done=%b after 128 pairs, want 1", done); end
        start = 1'b1; tick; start = 1'b0;
        vec++;
        if ({busy, llr_ready} !== 2'b00) begin
            miscmp++; $display("FAIL done_start: busy/ready=%b, want 00", {busy, llr_ready});
        end
        tick;
        vec++;
        if ({busy, llr_ready} !== 2'b00 || dec_bits !== {256'd0, {256{1'b1}}}) begin
            miscmp++; $display("FAIL b2b_after: busy/ready=%b dec_low_ok=%b", {busy, llr_ready}, dec_bits[255:0] === {256{1'b1}});
        end
    endtask

    task automatic test_long;
        logic v, u1, u2;
        logic [7:0] idx;
        frozen_mask = '0;
        pulse_start(2'd3);
        for (int k = 0; k < 256; k++) send_pair(-1, -1, v, u1, u2, idx);
        vec++;
        if (done !== 1'b1 || dec_bits !== {256{2'b10}}) begin
            miscmp++; $display("FAIL long: done=%b dec_bits[31:0]=%h, want 1 aaaaaaaa", done, dec_bits[31:0]);
        end
        tick;
    endtask

    task automatic test_skip;
        logic v, u1, u2;
        logic [7:0] idx;
        frozen_mask = '0;
        frozen_mask[2] = 1'b1; frozen_mask[3] = 1'b1;
        pulse_start(2'd0);
        send_pair(5, -3, v, u1, u2, idx);
`ifdef FROZEN_SKIP_EN
        vec++;
        if (llr_ready !== 1'b0) begin miscmp++; $display("FAIL skip_ready: llr_ready=%b, want 0", llr_ready); end
        tick;
        vec++;
        if ({ps_valid, skip, ps_u1, ps_u2, llr_ready} !== 5'b11000) begin
            miscmp++; $display("FAIL skip_pulse: valid/skip/u1/u2/ready=%b, want 11000", {ps_valid, skip, ps_u1, ps_u2, llr_ready});
        end
        tick;
        vec++;
        if ({skip, llr_ready, pair_idx} !== {2'b01, 8'd2}) begin
            miscmp++; $display("FAIL skip_next: skip/ready/idx=%b %b %0d, want 0 1 2", skip, llr_ready, pair_idx);
        end
`else
        vec++;
        if (llr_ready !== 1'b1) begin miscmp++; $display("FAIL noskip_ready: llr_ready=%b, want 1", llr_ready); end
        llr_1 = 17'h1FFFB; llr_2 = 17'd3; llr_valid = 1'b1;
        tick;
        llr_valid = 1'b0;
        vec++;
        if ({ps_valid, skip, ps_u1, ps_u2} !== 4'b1000) begin
            miscmp++; $display("FAIL noskip_pulse: valid/skip/u1/u2=%b, want 1000", {ps_valid, skip, ps_u1, ps_u2});
        end
`endif
        rst_n = 1'b0; tick; rst_n = 1'b1; tick;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_idle_llr;
        test_full_frame;
        test_decide;
        test_stall;
        test_reset_mid;
        test_back_to_back;
        test_long;
        test_skip;
        $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
        $finish;
    end

endmodule

// File: doc/sc_leaf_ctrl.md
SC_LEAF_CTRL -- requirements
Module: sc_leaf_ctrl

Interface
REQ-001 SHALL have ports as listed, one clock; reset asynchronous, active-low:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  async active-low reset
- start  in  1  one-cycle pulse, begin a decode frame
- len_sel  in  2  frame length: 0=128, 1=256, 2=512, 3=512
- frozen_mask  in  512  bit i=1 means u(i) frozen; held stable while busy
- llr_valid  in  1  upstream LLR pair valid
- llr_ready  out  1  controller accepts LLR pair
- llr_1  in  17  signed LLR for u(2k)
- llr_2  in  17  signed LLR for u(2k+1)
- pair_idx  out  8  current pair index k
- ps_valid  out  1  one-cycle partial-sum strobe
- ps_u1  out  1  decided u(2k)
- ps_u2  out  1  decided u(2k+1)
- dec_bits  out  512  decoded bits, u(i) at bit i
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse, frame complete
- skip  out  1  one-cycle pulse, pair decided without LLRs (macro only)

Function
REQ-002 SHALL implement FSM states IDLE, WAIT_LLR, DECIDE, DONE.
REQ-003 IDLE: start=1 -> WAIT_LLR; pair_idx<=0, dec_bits<=0, busy<=1; otherwise stay.
REQ-004 WAIT_LLR: llr_ready=1 only in this state; llr_valid&llr_ready -> capture llr_1, llr_2 and go to DECIDE.
REQ-005 DECIDE: compute pair decision from the captured LLRs and frozen_mask[2k], [2k+1]; write dec_bits[2k]=u1, [2k+1]=u2; assert ps_valid with ps_u1/ps_u2 for exactly one cycle.
REQ-006 From DECIDE: if k==pairs-1 (63/127/255 for len_sel) -> DONE, else k<=k+1 -> WAIT_LLR.
REQ-007 DONE: done=1 for one cycle, busy<=0, -> IDLE.
REQ-008 Latency: ps_valid is asserted on the cycle after the accepting handshake; minimum 2 cycles per pair.
REQ-009 Decision: s1=sign(llr_1), s2=sign(llr_2) (1 if negative); u1 = ~f1 & (s1^s2).
REQ-010 u2 = ~f2 & (f1 ? (comp ? s1 : s2) : s2), where comp = |llr_1| >= |llr_2|.
REQ-011 Magnitudes SHALL be computed at 18 bits so |-65536| does not overflow.
REQ-012 start while busy (including the DONE cycle) SHALL be ignored.
REQ-013 len_sel SHALL be sampled on start and held internally for the frame.
REQ-014 pair_idx SHALL remain stable from WAIT_LLR entry through DECIDE.
REQ-015 dec_bits SHALL hold its value after done until the next accepted start.
REQ-016 llr_valid with the controller outside WAIT_LLR SHALL have no effect.

Reset
REQ-017 rst_n low, asynchronously and at any point mid-frame: state=IDLE, pair_idx=0, dec_bits=0, llr_ready=0, ps_valid=0, ps_u1=0, ps_u2=0, busy=0, done=0, skip=0.
REQ-018 After reset release, the controller SHALL wait for a fresh start; no partial frame resumes.

Configuration
REQ-019 Macro FROZEN_SKIP_EN defined: in WAIT_LLR, if f1=f2=1, go directly to DECIDE without a handshake (llr_ready=0), decide u1=u2=0, and pulse skip alongside ps_valid.
REQ-020 Macro FROZEN_SKIP_EN undefined: every pair requires a handshake, and skip is tied to 0.

Verification
REQ-021 len_sel=0, all unfrozen, llr_1=+5, llr_2=-3 for all pairs -> 64 ps_valid strobes, each with u1=1, u2=1; done occurs 1 cycle after the last DECIDE.
REQ-022 f1=1, f2=0, llr_1=-10, llr_2=+4 -> u1=0, u2=1; then llr_1=+2, llr_2=-7 -> u2=1; llr_1=-65536, llr_2=+65535 -> u2=1.
REQ-023 llr_valid held low for 5 cycles in WAIT_LLR -> llr_ready stays 1, pair_idx is stable, no ps_valid.
REQ-024 rst_n pulsed low at pair 37 -> all outputs return to reset values immediately; start then replays the full frame correctly.
REQ-025 start during busy and during the DONE cycle -> ignored; len_sel changed mid-frame -> frame length unchanged.
REQ-026 With FROZEN_SKIP_EN, pair with f1=f2=1 and llr_valid=0 -> skip=1, ps_valid=1, u=00, llr_ready never 1 for that pair.
